// File: rtl/vermitypes_pkg.sv
// Shared Vermibus types: arbiter FSM states and the 1-bit master id.
package Vermitypes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    function automatic arb_state_t grant_state(input master_id_t id);
        return id ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/vermibus_arbiter_mux.sv
// Combinational datapath: steers the granted master's request to the slave and
// returns ready/rdata to that master only; all zeros while nothing is granted.
module vermibus_arbiter_mux
    import Vermitypes_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                grant_valid_i,
    input  master_id_t          grant_id_i,
    input  logic                m0_valid_i,
    input  logic [ADDR_W-1:0]   m0_address_i,
    input  logic [DATA_W/8-1:0] m0_wstrobe_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ready_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_valid_i,
    input  logic [ADDR_W-1:0]   m1_address_i,
    input  logic [DATA_W/8-1:0] m1_wstrobe_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ready_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_valid_o,
    output logic [ADDR_W-1:0]   s_address_o,
    output logic [DATA_W/8-1:0] s_wstrobe_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ready_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    always_comb begin
        s_valid_o   = 1'b0;
        s_address_o = '0;
        s_wstrobe_o = '0;
        s_wdata_o   = '0;
        m0_ready_o  = 1'b0;
        m0_rdata_o  = '0;
        m1_ready_o  = 1'b0;
        m1_rdata_o  = '0;
        if (grant_valid_i) begin
            if (grant_id_i == 1'b0) begin
                s_valid_o   = m0_valid_i;
                s_address_o = m0_address_i;
                s_wstrobe_o = m0_wstrobe_i;
                s_wdata_o   = m0_wdata_i;
                m0_ready_o  = s_ready_i;
                m0_rdata_o  = s_rdata_i;
            end else begin
                s_valid_o   = m1_valid_i;
                s_address_o = m1_address_i;
                s_wstrobe_o = m1_wstrobe_i;
                s_wdata_o   = m1_wdata_i;
                m1_ready_o  = s_ready_i;
                m1_rdata_o  = s_rdata_i;
            end
        end
    end

endmodule

// File: rtl/vermibus_arbiter.sv
// Two-master Vermibus arbiter: grant held for a whole transaction, zero-bubble
// handover. Macro VERMIBUS_ARBITER_ROUND_ROBIN_EN selects round-robin tie-break
// (defined) or fixed priority to master 0 (undefined).
module vermibus_arbiter
    import Vermitypes_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_wstrobe,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_wstrobe,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W/8-1:0] s_wstrobe,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W-1:0]   s_rdata,
    output arb_state_t          dbg_state_o,
    output master_id_t          dbg_last_o
);

    // Handshake: a master holds valid and its fields until it sees ready; ready
    // is a one-cycle completion pulse with rdata valid in that same cycle.
    arb_state_t state_q, state_d;
    master_id_t last_q, last_d;
    master_id_t tie_id;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
    assign tie_id = ~last_q;
`else
    assign tie_id = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) state_d = grant_state(tie_id);
                else if (m0_valid)        state_d = GRANT0;
                else if (m1_valid)        state_d = GRANT1;
            end
            // The owner's valid in its completion cycle belongs to the finished
            // request, so only the other master can claim the bus here.
            GRANT0: begin
                if (s_ready) begin
                    last_d  = 1'b0;
                    state_d = m1_valid ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (s_ready) begin
                    last_d  = 1'b1;
                    state_d = m0_valid ? GRANT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state_o = state_q;
    assign dbg_last_o  = last_q;

    vermibus_arbiter_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .grant_valid_i (state_q != IDLE),
        .grant_id_i    (state_q == GRANT1),
        .m0_valid_i    (m0_valid),
        .m0_address_i  (m0_address),
        .m0_wstrobe_i  (m0_wstrobe),
        .m0_wdata_i    (m0_wdata),
        .m0_ready_o    (m0_ready),
        .m0_rdata_o    (m0_rdata),
        .m1_valid_i    (m1_valid),
        .m1_address_i  (m1_address),
        .m1_wstrobe_i  (m1_wstrobe),
        .m1_wdata_i    (m1_wdata),
        .m1_ready_o    (m1_ready),
        .m1_rdata_o    (m1_rdata),
        .s_valid_o     (s_valid),
        .s_address_o   (s_address),
        .s_wstrobe_o   (s_wstrobe),
        .s_wdata_o     (s_wdata),
        .s_ready_i     (s_ready),
        .s_rdata_i     (s_rdata)
    );

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Bench for vermibus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level ownership model.
module tb_vermibus_arbiter;
    import Vermitypes_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_valid, m1_valid, m0_ready, m1_ready;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic [SW-1:0] m0_wstrobe, m1_wstrobe, s_wstrobe;
    logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic          s_valid, s_ready;
    arb_state_t    dbg_state;
    master_id_t    dbg_last;

    int checks = 0;
    int errors = 0;

    // Model: owner is -1 when the slave port is free, else the owning master.
    int owner  = -1;
    bit last_m = 1'b1;
    bit e_r0, e_r1;

    always #5 clk = ~clk;

    vermibus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_address(m0_address),
        .m0_wstrobe(m0_wstrobe), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_address(m1_address),
        .m1_wstrobe(m1_wstrobe), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_address(s_address),
        .s_wstrobe(s_wstrobe), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .dbg_state_o(dbg_state), .dbg_last_o(dbg_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic          ev, e0, e1;
        logic [AW-1:0] ea;
        logic [SW-1:0] es;
        logic [DW-1:0] ed, er0, er1;
        arb_state_t    est;
        @(negedge clk);
        ev = 1'b0; e0 = 1'b0; e1 = 1'b0;
        ea = '0; es = '0; ed = '0; er0 = '0; er1 = '0;
        est = IDLE;
        if (owner == 0) begin
            ev = m0_valid; ea = m0_address; es = m0_wstrobe; ed = m0_wdata;
            e0 = s_ready; er0 = s_rdata; est = GRANT0;
        end else if (owner == 1) begin
            ev = m1_valid; ea = m1_address; es = m1_wstrobe; ed = m1_wdata;
            e1 = s_ready; er1 = s_rdata; est = GRANT1;
        end
        chk("s_valid", 32'(s_valid), 32'(ev));
        chk("s_address", s_address, ea);
        chk("s_wstrobe", 32'(s_wstrobe), 32'(es));
        chk("s_wdata", s_wdata, ed);
        chk("m0_ready", 32'(m0_ready), 32'(e0));
        chk("m1_ready", 32'(m1_ready), 32'(e1));
        chk("m0_rdata", m0_rdata, er0);
        chk("m1_rdata", m1_rdata, er1);
        chk("state", 32'(dbg_state), 32'(est));
        chk("last", 32'(dbg_last), 32'(last_m));
        e_r0 = e0;
        e_r1 = e1;
    endtask

    task automatic advance();
        bit other_valid;
        @(posedge clk);
        if (!reset) begin
            owner  = -1;
            last_m = 1'b1;
        end else if (owner < 0) begin
            if (m0_valid && m1_valid) owner = RR ? (last_m ? 0 : 1) : 0;
            else if (m0_valid)        owner = 0;
            else if (m1_valid)        owner = 1;
        end else if (s_ready) begin
            other_valid = (owner == 0) ? m1_valid : m0_valid;
            last_m = (owner == 1);
            owner  = other_valid ? 1 - owner : -1;
        end
        #1;
    endtask

    // One bus cycle with a well-behaved slave and masters that drop valid
    // after completion and optionally issue fresh random requests.
    task automatic bus_cycle(input bit allow_new);
        bit r0, r1;
        sample();
        r0 = e_r0;
        r1 = e_r1;
        advance();
        s_ready = 1'b0;
        s_rdata = $urandom;
        if (r0) m0_valid = 1'b0;
        if (r1) m1_valid = 1'b0;
        if (allow_new) begin
            if (!m0_valid && $urandom_range(0, 2) == 0) begin
                m0_valid = 1'b1; m0_address = $urandom;
                m0_wstrobe = 4'($urandom_range(0, 15)); m0_wdata = $urandom;
            end
            if (!m1_valid && $urandom_range(0, 2) == 0) begin
                m1_valid = 1'b1; m1_address = $urandom;
                m1_wstrobe = 4'($urandom_range(0, 15)); m1_wdata = $urandom;
            end
        end
        if (owner >= 0 && $urandom_range(0, 2) == 0) s_ready = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((owner >= 0 || m0_valid || m1_valid) && n < 60) begin
            bus_cycle(1'b0);
            n++;
        end
        chk(tag, 32'(owner >= 0 || m0_valid || m1_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        sample(); advance();
        sample(); advance();
        reset = 1'b1;
    endtask

    task automatic both_round(input string tag, input logic [31:0] exp_first);
        m0_valid = 1'b1; m0_address = 32'h1000; m0_wstrobe = 4'h0; m0_wdata = $urandom;
        m1_valid = 1'b1; m1_address = 32'h2000; m1_wstrobe = 4'hF; m1_wdata = $urandom;
        sample(); chk({tag, "_latency"}, 32'(s_valid), 32'd0); advance();
        sample(); chk(tag, s_address, exp_first); advance();
        drain({tag, "_drain"});
    endtask

    initial begin
        reset = 1'b0;
        m0_valid = 1'b0; m0_address = '0; m0_wstrobe = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_address = '0; m1_wstrobe = '0; m1_wdata = '0;
        s_ready = 1'b0; s_rdata = '0;
        advance();
        do_reset();

        // Single read with two slave wait cycles
        m0_valid = 1'b1; m0_address = 32'h100; m0_wstrobe = 4'h0;
        sample(); chk("sr_latency", 32'(s_valid), 32'd0); advance();
        sample(); chk("sr_svalid", 32'(s_valid), 32'd1); chk("sr_addr", s_address, 32'h100); advance();
        sample(); advance();
        s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
        sample();
        chk("sr_ready", 32'(m0_ready), 32'd1);
        chk("sr_rdata", m0_rdata, 32'hDEADBEEF);
        chk("sr_m1_ready", 32'(m1_ready), 32'd0);
        advance();
        s_ready = 1'b0; m0_valid = 1'b0;
        sample(); chk("sr_idle", 32'(dbg_state), 32'(IDLE)); advance();

        // Simultaneous requests: first after reset always goes to m0
        do_reset();
        both_round("tie_first", 32'h1000);
        m0_valid = 1'b1; m0_address = 32'h400; m0_wstrobe = 4'h0;
        drain("solo_m0");
        both_round("tie_second", RR ? 32'h2000 : 32'h1000);

        // Rounds from a fresh reset: handover leaves last at m1, so m0 wins
        do_reset();
        for (int r = 0; r < 4; r++) both_round("tie_round", 32'h1000);

        // Handover from an m1 write to a waiting m0
        m1_valid = 1'b1; m1_address = 32'h200; m1_wstrobe = 4'b0011; m1_wdata = 32'h1234;
        sample(); advance();
        sample();
        chk("ho_addr", s_address, 32'h200);
        chk("ho_strobe", 32'(s_wstrobe), 32'h3);
        chk("ho_wdata", s_wdata, 32'h1234);
        advance();
        m0_valid = 1'b1; m0_address = 32'h300; m0_wstrobe = 4'h0;
        sample(); chk("ho_m0_wait", 32'(m0_ready), 32'd0); advance();
        s_ready = 1'b1;
        sample(); chk("ho_m1_done", 32'(m1_ready), 32'd1); chk("ho_m0_hold", 32'(m0_ready), 32'd0); advance();
        s_ready = 1'b0; m1_valid = 1'b0;
        sample();
        chk("ho_no_bubble", 32'(s_valid), 32'd1);
        chk("ho_next_addr", s_address, 32'h300);
        chk("ho_m0_pending", 32'(m0_ready), 32'd0);
        advance();
        s_ready = 1'b1;
        sample(); chk("ho_m0_done", 32'(m0_ready), 32'd1); advance();
        s_ready = 1'b0; m0_valid = 1'b0;
        sample(); advance();

        // Reset during GRANT0, then a late slave completion
        m0_valid = 1'b1; m0_address = 32'h500;
        sample(); advance();
        sample(); chk("rst_granted", 32'(dbg_state), 32'(GRANT0)); advance();
        reset = 1'b0;
        sample(); advance();
        m0_valid = 1'b0; reset = 1'b1; s_ready = 1'b1; s_rdata = 32'hCAFEF00D;
        sample();
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_svalid", 32'(s_valid), 32'd0);
        chk("rst_late_ready", 32'(m0_ready), 32'd0);
        chk("rst_late_rdata", m0_rdata, 32'd0);
        advance();
        s_ready = 1'b0;

        // Idle isolation from a slave driving all ones
        s_rdata = 32'hFFFFFFFF;
        sample();
        chk("iso_rdata0", m0_rdata, 32'd0);
        chk("iso_rdata1", m1_rdata, 32'd0);
        chk("iso_svalid", 32'(s_valid), 32'd0);
        advance();

        // Random traffic
        for (int i = 0; i < 400; i++) bus_cycle(1'b1);
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
